// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: bus structs, fetch payload,
// decode next-PC verdicts and the fetch FSM state encoding.
package fetch_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   typedef enum logic [2:0] {
      PLUS4  = 3'd0,
      N_BEQ  = 3'd1,
      F_BEQ  = 3'd2,
      F_JAL  = 3'd3,
      F_MRET = 3'd4
   } instfunc_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DROP = 3'd3,
      HOLD = 3'd4
   } fetch_state_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic            addr_ok;
      logic            data_ok;
      logic [ILEN-1:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic [ILEN-1:0] raw_instr;
      logic [XLEN-1:0] pc;
      logic            stall;
   } fetch_data_t;

   // Sequential successor; wraps naturally at 2^64.
   function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Redirect priority mux: commit trap beats MRET, which beats taken branch/jump.
// Targets are passed through unaligned; misalignment is caught downstream.
module fetch_npc_sel
   import fetch_pkg::*;
(
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            dec_fire_i,
   input  instfunc_t       op_i,
   input  logic [XLEN-1:0] offset_i,
   input  logic [XLEN-1:0] dec_pc_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic            redirect_o,
   output logic [XLEN-1:0] target_o
);

   always_comb begin
      redirect_o = 1'b0;
      target_o   = '0;
      if (trap_valid_i) begin
         redirect_o = 1'b1;
         target_o   = trap_pc_i;
      end else if (dec_fire_i) begin
         case (op_i)
            F_MRET: begin
               redirect_o = 1'b1;
               target_o   = mepc_i;
            end
            F_BEQ, F_JAL: begin
               redirect_o = 1'b1;
               target_o   = dec_pc_i + offset_i;
            end
            default: begin
               redirect_o = 1'b0;
               target_o   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fetch.sv
// IF stage: owns the PC, keeps at most one ibus request outstanding and buffers
// one instruction for decode, discarding wrong-path responses after a redirect.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] PC_RESET = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output ibus_req_t       ireq,
   input  ibus_resp_t      iresp,
   output fetch_data_t     dataF,
   input  logic            dec_ready,
   input  logic            dec_fire,
   input  instfunc_t       op,
   input  logic [XLEN-1:0] offset,
   input  logic [XLEN-1:0] dec_pc,
   input  logic [XLEN-1:0] mepc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            pend_q, pend_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic            redirect;
   logic [XLEN-1:0] target;

   fetch_npc_sel u_npc_sel (
      .trap_valid_i (trap_valid),
      .trap_pc_i    (trap_pc),
      .dec_fire_i   (dec_fire),
      .op_i         (op),
      .offset_i     (offset),
      .dec_pc_i     (dec_pc),
      .mepc_i       (mepc),
      .redirect_o   (redirect),
      .target_o     (target)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= PC_RESET;
         pend_pc_q <= '0;
         pend_q    <= 1'b0;
         instr_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         pend_q    <= pend_d;
         instr_q   <= instr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      pend_d    = pend_q;
      instr_d   = instr_q;
      case (state_q)
         IDLE: begin
            state_d = REQ;
            if (redirect) pc_d = target;
         end
         // The address must stay put until accepted, so a redirect here is only
         // remembered; the response it produces is then thrown away in DROP.
         REQ: begin
            if (redirect) begin
               pend_d    = 1'b1;
               pend_pc_d = target;
            end
            if (iresp.addr_ok) state_d = (pend_q || redirect) ? DROP : WAIT;
         end
         WAIT: begin
            if (redirect) begin
               pc_d      = target;
               pend_pc_d = target;
               state_d   = iresp.data_ok ? REQ : DROP;
            end else if (iresp.data_ok) begin
               instr_d = iresp.data;
               state_d = HOLD;
            end
         end
         DROP: begin
            if (redirect) pend_pc_d = target;
            if (iresp.data_ok) begin
               pc_d    = redirect ? target : pend_pc_q;
               pend_d  = 1'b0;
               state_d = REQ;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = REQ;
            end else if (dec_ready) begin
               pc_d    = seq_pc(pc_q);
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A redirect seen while holding kills the buffered instruction immediately.
   always_comb begin
      ireq.valid      = (state_q == REQ);
      ireq.addr       = pc_q;
      dataF.raw_instr = '0;
      dataF.pc        = '0;
      dataF.stall     = 1'b1;
      if (state_q == HOLD && !redirect) begin
         dataF.raw_instr = instr_q;
         dataF.pc        = pc_q;
         dataF.stall     = 1'b0;
      end
   end

endmodule
